// File: rtl/fft_adc_feeder_pkg.sv
// ---------------------------------------------------------------------------
// fft_adc_feeder_pkg
//   Shared definitions for the ADC-to-FFT sample feeder:
//     - fd_state_e : feeder state encoding (IDLE / STREAM / WAIT_DONE)
//     - Q15_W      : width of the Q1.15 sample word handed to fft_process
//     - to_q15     : final step of the raw-code to Q1.15 conversion
// ---------------------------------------------------------------------------
package fft_adc_feeder_pkg;

  localparam int Q15_W = 16;

  typedef enum logic [1:0] {
    FD_IDLE      = 2'd0,
    FD_STREAM    = 2'd1,
    FD_WAIT_DONE = 2'd2
  } fd_state_e;

  // Takes a code that is already left-aligned into 16 bits. Offset-binary
  // codes become two's complement by flipping the sign bit; the lower bits
  // are untouched, so there is no rounding and no saturation.
  function automatic logic [Q15_W-1:0] to_q15(input logic [Q15_W-1:0] aligned,
                                              input logic             offset_binary);
    logic [Q15_W-1:0] q;
    q = aligned;
    if (offset_binary) begin
      q[Q15_W-1] = ~q[Q15_W-1];
    end
    return q;
  endfunction

endpackage

// File: rtl/fft_adc_feeder_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
//   Divides clk down to the FFT sample rate. div_cnt runs 0..CLK_DIV-1 and
//   wraps; tick is high while div_cnt sits at CLK_DIV-1. With CLK_DIV=1
//   tick is high every cycle.
// Ports
//   clk   in  system clock
//   rst   in  synchronous reset, active-high (div_cnt -> 0)
//   clear in  synchronous restart of the divider (div_cnt -> 0)
//   tick  out one-cycle-wide sample strobe
// ---------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/fft_adc_feeder.sv
// ---------------------------------------------------------------------------
// fft_adc_feeder
//   Producer side of the fft_process sample interface. Decimates raw ADC
//   codes to the FFT sample rate, converts each kept code to Q1.15 and
//   delivers exactly FRAME_LEN samples per frame, gated by ready_for_data.
//   After a full frame it waits for processing_done before re-arming.
// Ports
//   clk, rst          clock and synchronous active-high reset
//   enable            1 = run, 0 = abort and hold in IDLE
//   continuous        1 = re-arm after processing_done, 0 = one frame per enable rise
//   adc_raw           raw ADC code, only looked at on tick cycles
//   ready_for_data    sink can accept a sample
//   processing_done   sink has finished the frame
//   adc_input         Q1.15 sample (holds between strobes)
//   adc_valid         one-cycle strobe per delivered sample
//   sample_count      samples delivered in the current frame
//   frame_active      high while streaming
//   frame_done        pulse with the FRAME_LEN-th adc_valid
//   overrun           sticky: a tick was missed because the sink was not ready
// ---------------------------------------------------------------------------
module fft_adc_feeder
  import fft_adc_feeder_pkg::*;
#(
  parameter int ADC_WIDTH     = 12,
  parameter int OFFSET_BINARY = 1,
  parameter int CLK_DIV       = 2,
  parameter int FRAME_LEN     = 2400,
  parameter int CNT_W         = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 continuous,
  input  logic [ADC_WIDTH-1:0] adc_raw,
  input  logic                 ready_for_data,
  input  logic                 processing_done,
  output logic [Q15_W-1:0]     adc_input,
  output logic                 adc_valid,
  output logic [CNT_W-1:0]     sample_count,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_LEN);
  localparam logic             OB_MODE    = (OFFSET_BINARY != 0);

  fd_state_e        state, state_d;
  logic             armed, armed_d;
  logic [Q15_W-1:0] adc_input_d;
  logic             adc_valid_d;
  logic [CNT_W-1:0] sample_count_d;
  logic             frame_done_d;
  logic             overrun_d;
  logic             tick_raw;
  logic             tick;
  logic [Q15_W-1:0] q_sample;
  logic [CNT_W-1:0] count_inc;

  // The divider is held at zero whenever we are not streaming, so it always
  // restarts from 0 on the first STREAM cycle.
  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (state != FD_STREAM),
    .tick  (tick_raw)
  );

  assign tick = tick_raw && (state == FD_STREAM);

  // Left-align the raw code into 16 bits, then fix up the sign bit.
  assign q_sample  = to_q15(Q15_W'(adc_raw) << (Q15_W - ADC_WIDTH), OB_MODE);
  assign count_inc = sample_count + CNT_W'(1);

  // Next-state and next-output logic. enable=0 overrides every state so an
  // abort always lands in IDLE without a frame_done; sample_count and overrun
  // are left alone so software can still read where the frame stopped.
  always_comb begin
    state_d        = state;
    armed_d        = armed;
    adc_input_d    = adc_input;
    adc_valid_d    = 1'b0;
    sample_count_d = sample_count;
    frame_done_d   = 1'b0;
    overrun_d      = overrun;

    if (!enable) begin
      state_d = FD_IDLE;
      armed_d = 1'b1;
    end else begin
      case (state)
        FD_IDLE: begin
          if (armed && ready_for_data) begin
            state_d        = FD_STREAM;
            sample_count_d = '0;
            overrun_d      = 1'b0;
          end
        end
        FD_STREAM: begin
          if (tick) begin
            if (ready_for_data) begin
              adc_input_d    = q_sample;
              adc_valid_d    = 1'b1;
              sample_count_d = count_inc;
              if (count_inc == LAST_COUNT) begin
                frame_done_d = 1'b1;
                state_d      = FD_WAIT_DONE;
              end
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        FD_WAIT_DONE: begin
          if (processing_done) begin
            state_d = FD_IDLE;
            armed_d = continuous;
          end
        end
        default: begin
          state_d = FD_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FD_IDLE;
      armed        <= 1'b1;
      adc_input    <= '0;
      adc_valid    <= 1'b0;
      sample_count <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      armed        <= armed_d;
      adc_input    <= adc_input_d;
      adc_valid    <= adc_valid_d;
      sample_count <= sample_count_d;
      frame_done   <= frame_done_d;
      overrun      <= overrun_d;
    end
  end

  assign frame_active = (state == FD_STREAM);

endmodule
